// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo - transmit-side byte buffer feeding uart_core.
//
// Host bytes enter over a valid/ready write port and are stored in a circular FIFO.
// A small FSM pops one byte at a time into tx_data and pulses tx_start. It then waits
// for uart_core to raise and drop tx_busy before the next frame. A new frame starts
// only while cts is high.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   wr_data, wr_valid   host byte and write request
//   wr_ready            registered !full
//   tx_data             byte presented to uart_core, held for the whole frame
//   tx_start            one-cycle frame request
//   tx_busy             uart_core is serialising a frame
//   cts                 clear-to-send from the link partner
//   level, empty        FIFO occupancy (0..DEPTH) and level == 0
//   overflow            sticky: a write was attempted while full (byte dropped)
//
// Optional build macro UART_TX_FIFO_STATS_EN adds:
//   tx_count            16-bit wrapping count of tx_start pulses
//   hwm                 high-water mark of level
module uart_tx_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   input  logic              cts,
   output logic [LVL_W-1:0]  level,
   output logic              empty,
   output logic              overflow
`ifdef UART_TX_FIFO_STATS_EN
   ,
   output logic [15:0]       tx_count,
   output logic [LVL_W-1:0]  hwm
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StArm, StSend} state_e;

   state_e              state_q, state_d;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]    level_q, level_d;
   logic                wr_ready_q;
   logic [DATA_W-1:0]   tx_data_q;
   logic                tx_start_q;
   logic                overflow_q;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                push, pop;

   assign empty = (level_q == '0);
   assign push  = wr_valid && wr_ready_q;

   // Frame sequencing: IDLE pops, ARM waits for uart_core to go busy, SEND waits for it
   // to finish. Returning through IDLE guarantees at least one idle cycle between frames.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty && cts && !tx_busy) begin
               pop     = 1'b1;
               state_d = StArm;
            end
         end
         StArm:   if (tx_busy)  state_d = StSend;
         StSend:  if (!tx_busy) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (!push && pop) begin
         level_d = level_q - 1'b1;
      end
   end

   // Storage is not reset; only the pointers and level define valid contents.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         wr_ready_q <= 1'b1;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         // Registered from the next level, so a pop at full frees the slot one cycle later.
         wr_ready_q <= (level_d != LVL_W'(DEPTH));
         tx_start_q <= pop;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            tx_data_q <= mem[rd_ptr_q];
         end
         if (wr_valid && !wr_ready_q) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign wr_ready = wr_ready_q;
   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;
   assign level    = level_q;
   assign overflow = overflow_q;

`ifdef UART_TX_FIFO_STATS_EN
   logic [15:0]      tx_count_q;
   logic [LVL_W-1:0] hwm_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_count_q <= '0;
         hwm_q      <= '0;
      end else begin
         if (tx_start_q) begin
            tx_count_q <= tx_count_q + 16'd1;
         end
         if (level_q > hwm_q) begin
            hwm_q <= level_q;
         end
      end
   end

   assign tx_count = tx_count_q;
   assign hwm      = hwm_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural uart_core model that stays busy for
// 10 bit times per frame and records every byte it accepts.
module tb_uart_tx_fifo;

   localparam int unsigned DEPTH   = 16;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned LVL_W   = 5;
   localparam int unsigned BIT_CLK = 2;
   localparam int unsigned FRAME   = 10 * BIT_CLK;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [DATA_W-1:0] wr_data = '0;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [DATA_W-1:0] tx_data;
   logic              tx_start;
   logic              tx_busy;
   logic              cts = 1'b1;
   logic [LVL_W-1:0]  level;
   logic              empty;
   logic              overflow;
`ifdef UART_TX_FIFO_STATS_EN
   logic [15:0]       tx_count;
   logic [LVL_W-1:0]  hwm;
`endif

   uart_tx_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .LVL_W  (LVL_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_data  (wr_data),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_busy  (tx_busy),
      .cts      (cts),
      .level    (level),
      .empty    (empty),
      .overflow (overflow)
`ifdef UART_TX_FIFO_STATS_EN
      ,
      .tx_count (tx_count),
      .hwm      (hwm)
`endif
   );

   always #5 clk = ~clk;

   // uart_core model
   logic [7:0] sent [$];
   logic [7:0] frame_q;
   int         busy_cnt;
   int         n_start = 0;
   int         stable_err = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_busy  <= 1'b0;
         busy_cnt <= 0;
      end else if (tx_busy) begin
         if (tx_data != frame_q) stable_err <= stable_err + 1;
         if (busy_cnt == 0) tx_busy <= 1'b0;
         else busy_cnt <= busy_cnt - 1;
      end else if (tx_start) begin
         tx_busy  <= 1'b1;
         busy_cnt <= FRAME - 1;
         frame_q  <= tx_data;
         sent.push_back(tx_data);
      end
   end

   always @(posedge clk) begin
      if (tx_start) n_start <= n_start + 1;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // All tasks are entered and left on a falling edge.
   task automatic push(input logic [7:0] b);
      wr_data  = b;
      wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_busy(input string tag, input int max);
      for (int i = 0; i < max; i++) begin
         if (tx_busy) break;
         @(negedge clk);
      end
      check(tag, 32'(tx_busy), 32'd1);
   endtask

   task automatic drain(input string tag, input int max);
      int quiet;
      quiet = 0;
      for (int i = 0; i < max && quiet < 3; i++) begin
         @(negedge clk);
         if (level == '0 && !tx_busy && !tx_start) quiet++;
         else quiet = 0;
      end
      check(tag, 32'(quiet), 32'd3);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   int         base;
   int         s0;
   int         idx;
   logic       rdy_prev;
   logic       prev_full;
   logic       saw;
   logic       chk_next;
   logic [7:0] exp_b;

   initial begin
      // Reset state
      #2 rst_n = 1'b0;
      #1;
      check("rst_level", 32'(level), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_wr_ready", 32'(wr_ready), 32'd1);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      tick(2);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: single byte, tx_start two edges after the push edge
      base = sent.size();
      s0   = n_start;
      push(8'h77);
      check("t1_level_after_push", 32'(level), 32'd1);
      check("t1_no_early_start", 32'(tx_start), 32'd0);
      @(negedge clk);
      check("t1_start", 32'(tx_start), 32'd1);
      check("t1_data", 32'(tx_data), 32'h77);
      check("t1_level_after_pop", 32'(level), 32'd0);
      check("t1_empty", 32'(empty), 32'd1);
      @(negedge clk);
      check("t1_start_one_cycle", 32'(tx_start), 32'd0);
      drain("t1_drain", 200);
      check("t1_pulses", 32'(n_start - s0), 32'd1);
      check("t1_sent_cnt", 32'(sent.size() - base), 32'd1);
      check("t1_sent", 32'(sent[base]), 32'h77);

      // 2: back-to-back burst, serial order and stable tx_data
      base = sent.size();
      s0   = n_start;
      push(8'h77);
      push(8'hAA);
      push(8'h33);
      drain("t2_drain", 400);
      check("t2_pulses", 32'(n_start - s0), 32'd3);
      check("t2_sent_cnt", 32'(sent.size() - base), 32'd3);
      check("t2_sent0", 32'(sent[base]), 32'h77);
      check("t2_sent1", 32'(sent[base+1]), 32'hAA);
      check("t2_sent2", 32'(sent[base+2]), 32'h33);
      check("t2_stable", 32'(stable_err), 32'd0);
      check("t2_no_overflow", 32'(overflow), 32'd0);

      // 3: cts low, fill to DEPTH, overflow on 17th, then release
      cts  = 1'b0;
      base = sent.size();
      s0   = n_start;
      for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
      check("t3_level_full", 32'(level), 32'd16);
      check("t3_not_ready", 32'(wr_ready), 32'd0);
      check("t3_not_empty", 32'(empty), 32'd0);
      push(8'hEE);
      check("t3_overflow", 32'(overflow), 32'd1);
      check("t3_level_kept", 32'(level), 32'd16);
      tick(5);
      check("t3_no_start", 32'(n_start - s0), 32'd0);
`ifdef UART_TX_FIFO_STATS_EN
      check("t3_hwm", 32'(hwm), 32'd16);
`endif
      cts = 1'b1;
      drain("t3_drain", 1000);
      check("t3_sent_cnt", 32'(sent.size() - base), 32'd16);
      for (int i = 0; i < 16; i++) begin
         exp_b = 8'h10 + 8'(i);
         check("t3_order", 32'(sent[base+i]), 32'(exp_b));
      end

      // 4: cts drops while frame 1 of 3 is in SEND
      base = sent.size();
      s0   = n_start;
      push(8'h41);
      push(8'h42);
      push(8'h43);
      wait_busy("t4_busy", 20);
      tick(2);
      cts = 1'b0;
      tick(40);
      check("t4_one_sent", 32'(sent.size() - base), 32'd1);
      check("t4_one_pulse", 32'(n_start - s0), 32'd1);
      check("t4_queued", 32'(level), 32'd2);
      cts = 1'b1;
      drain("t4_drain", 300);
      check("t4_sent_cnt", 32'(sent.size() - base), 32'd3);
      check("t4_sent0", 32'(sent[base]), 32'h41);
      check("t4_sent1", 32'(sent[base+1]), 32'h42);
      check("t4_sent2", 32'(sent[base+2]), 32'h43);

      // 5: continuous writes with cts high; push at full with a pop is refused, then taken
      base      = sent.size();
      idx       = 0;
      rdy_prev  = 1'b0;
      prev_full = 1'b0;
      saw       = 1'b0;
      chk_next  = 1'b0;
      for (int c = 0; c < 2000 && idx < 20; c++) begin
         @(negedge clk);
         if (wr_valid && rdy_prev) idx++;
         if (chk_next) begin
            check("t5_refill_level", 32'(level), 32'd16);
            check("t5_refill_ready", 32'(wr_ready), 32'd0);
            chk_next = 1'b0;
         end
         if (prev_full && level == 5'd15 && !saw) begin
            check("t5_ready_after_pop", 32'(wr_ready), 32'd1);
            saw      = 1'b1;
            chk_next = 1'b1;
         end
         if (level == 5'd16) check("t5_full_not_ready", 32'(wr_ready), 32'd0);
         prev_full = (level == 5'd16);
         if (idx < 20) begin
            wr_data  = 8'h80 + idx[7:0];
            wr_valid = 1'b1;
         end else begin
            wr_valid = 1'b0;
         end
         rdy_prev = wr_ready;
      end
      wr_valid = 1'b0;
      check("t5_all_accepted", 32'(idx), 32'd20);
      check("t5_full_pop_seen", 32'(saw), 32'd1);
      drain("t5_drain", 2000);
      check("t5_sent_cnt", 32'(sent.size() - base), 32'd20);
      for (int i = 0; i < 20; i++) begin
         exp_b = 8'h80 + 8'(i);
         check("t5_order", 32'(sent[base+i]), 32'(exp_b));
      end
      check("t5_stable", 32'(stable_err), 32'd0);

      // 6: asynchronous reset mid-SEND with 5 bytes queued
      s0 = n_start;
      for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
      wait_busy("t6_busy", 20);
      tick(2);
      check("t6_queued", 32'(level), 32'd5);
      rst_n = 1'b0;
      #1;
      check("t6_rst_level", 32'(level), 32'd0);
      check("t6_rst_empty", 32'(empty), 32'd1);
      check("t6_rst_wr_ready", 32'(wr_ready), 32'd1);
      check("t6_rst_tx_start", 32'(tx_start), 32'd0);
      check("t6_rst_tx_data", 32'(tx_data), 32'd0);
      check("t6_rst_overflow", 32'(overflow), 32'd0);
`ifdef UART_TX_FIFO_STATS_EN
      check("t6_rst_tx_count", 32'(tx_count), 32'd0);
      check("t6_rst_hwm", 32'(hwm), 32'd0);
`endif
      tick(2);
      rst_n = 1'b1;
      tick(40);
      check("t6_no_start_after_rst", 32'(n_start - s0), 32'd1);
      check("t6_still_empty", 32'(empty), 32'd1);
      base = sent.size();
      push(8'h5A);
      drain("t6_drain", 200);
      check("t6_new_pulse", 32'(n_start - s0), 32'd2);
      check("t6_sent_cnt", 32'(sent.size() - base), 32'd1);
      check("t6_sent", 32'(sent[base]), 32'h5A);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer directly upstream of uart_core.
- Accepts bytes from a host over a valid/ready write port and stores them in a circular FIFO.
- Presents bytes one at a time to uart_core's transmit data input, with a start/busy handshake.
- Gates each new frame on the link's clear-to-send flow control, so host bursts never overrun the serial link.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥ 2.
- DATA_W, 8, byte width; must match uart_core txdata width.
- LVL_W, $clog2(DEPTH)+1, width of the fill-level output.

Ports:
- clk  in  1  system clock, same clock as uart_core.
- rst_n  in  1  asynchronous active-low reset.
- wr_data  in  DATA_W  host byte to enqueue.
- wr_valid  in  1  host write request.
- wr_ready  out  1  FIFO can accept; equals !full.
- tx_data  out  DATA_W  byte presented to uart_core txdata; held stable for the whole frame.
- tx_start  out  1  one-cycle pulse requesting a frame.
- tx_busy  in  1  uart_core serialising a frame.
- cts  in  1  clear-to-send from link partner; high = may start a new frame.
- level  out  LVL_W  current FIFO occupancy, 0..DEPTH.
- empty  out  1  level == 0.
- overflow  out  1  sticky: a write was attempted while full.

Behaviour:
- Reset (rst_n low, async): rd/wr pointers = 0, level = 0, empty = 1, wr_ready = 1, tx_data = 0, tx_start = 0, overflow = 0, FSM = IDLE. Release is sampled on the rising clk edge.
- Push:
  - Occurs on a clk edge with wr_valid && wr_ready.
  - Writes mem[wr_ptr]; wr_ptr wraps from DEPTH-1 to 0.
  - wr_ready and level are registered. A push and a pop in the same cycle leave level unchanged.
  - When full, wr_ready = 0 even if a pop happens that cycle; the freed slot is visible one cycle later.
- Overflow: wr_valid && !wr_ready sets overflow; it clears only on reset. The byte is dropped.
- FSM:
  - IDLE: if !empty && cts && !tx_busy → pop mem[rd_ptr] into tx_data, rd_ptr++ (wraps), assert tx_start for one cycle, go ARM.
  - ARM: wait for tx_busy = 1, then go SEND. tx_start is not re-asserted.
  - SEND: wait for tx_busy = 0, then go IDLE.
- Minimum gap: 1 cycle in IDLE between frames.
- Latency: a byte pushed into an empty FIFO with cts = 1 produces tx_start 2 clk edges after the push edge (1 cycle for level update, 1 for the pop).
- cts low: no new frame starts. A frame already in ARM/SEND runs to completion. Bytes stay queued.
- tx_data changes only on a pop edge.
- Empty with cts high: FSM stays in IDLE and tx_start stays 0.
- Mid-operation reset: the FIFO is discarded and the FSM returns to IDLE. uart_core is reset by the same rst_n, so no frame is orphaned.
- Pointers are log2(DEPTH) bits with natural wrap; level is tracked as a separate counter.

Optional Feature:
- Macro: UART_TX_FIFO_STATS_EN.
- Defined: adds output tx_count, 16 bits, reset 0. It increments on every tx_start pulse, wraps 0xFFFF→0, and is not cleared except by reset. Also adds output hwm, LVL_W bits: the high-water mark of level, reset 0, updated as max(hwm, level) every cycle.
- Undefined: both ports and their logic are absent; the port list is exactly as above.

Test Plan:
1. Reset, cts = 1, push 0x77 → tx_data = 0x77 and a single tx_start pulse 2 cycles later; level 1→0; empty returns to 1.
2. Push 0x77, 0xAA, 0x33 back-to-back, uart_core model busy 10·BIT_CLK per frame → serial order 0x77, 0xAA, 0x33; exactly 3 tx_start pulses; tx_data stable while tx_busy = 1.
3. cts = 0, push DEPTH (16) bytes → wr_ready = 0, level = 16, no tx_start. Push a 17th → overflow = 1, byte dropped. Raise cts → 16 frames in order with no loss.
4. Drop cts while frame 1 of 3 is in SEND → frame 1 completes; frames 2–3 wait; both go out after cts rises.
5. Fill to 16 with cts = 1 and simultaneous push/pop at full → push refused that cycle and accepted the next; pointer wrap past index 15 preserves order.
6. Assert rst_n low mid-SEND with 5 bytes queued → outputs at reset values immediately (async); after release, no tx_start until a new push. With UART_TX_FIFO_STATS_EN, tx_count = 0 and hwm = 0.
